// File: rtl/mult_rr_pkg.sv
// mult_rr_pkg
//   Shared constants and types for the round-robin multiplier scheduler.
//   DATA_W   operand width
//   PROD_W   product width
//   MULT_LAT pipeline depth of the shared multiplier (and of the tag pipe)
//   TAG_ID_W tag ID width, sized for the largest supported requester count (8)
//   tag_t    one tag-pipe stage: valid bit plus requester ID
package mult_rr_pkg;

  localparam int DATA_W   = 8;
  localparam int PROD_W   = 16;
  localparam int MULT_LAT = 5;
  localparam int MAX_NREQ = 8;
  localparam int TAG_ID_W = $clog2(MAX_NREQ);

  typedef struct packed {
    logic                v;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/pipelined_multiplier_8bit.sv
// pipelined_multiplier_8bit
//   Unsigned 8x8 -> 16 multiplier, fixed 5-cycle latency, no valid/stall.
//   Operands presented before edge N appear on p after edge N+4.
//   Ports:
//     clk  in   clock
//     rst  in   asynchronous active-high reset, clears every stage
//     a    in   [7:0]  operand A
//     b    in   [7:0]  operand B
//     p    out  [15:0] product
module pipelined_multiplier_8bit
  import mult_rr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [PROD_W-1:0] p
);

  logic [DATA_W-1:0] a_q, b_q;
  logic [11:0]       pp_lo_q, pp_hi_q;
  logic [PROD_W-1:0] sum_q, dly_q, p_q;

  // Split B into nibbles so the widest single-stage operation is 8x4.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      pp_lo_q <= '0;
      pp_hi_q <= '0;
      sum_q   <= '0;
      dly_q   <= '0;
      p_q     <= '0;
    end else begin
      a_q     <= a;
      b_q     <= b;
      pp_lo_q <= 12'(a_q) * 12'(b_q[3:0]);
      pp_hi_q <= 12'(a_q) * 12'(b_q[7:4]);
      sum_q   <= {pp_hi_q, 4'b0000} + 16'(pp_lo_q);
      dly_q   <= sum_q;
      p_q     <= dly_q;
    end
  end

  assign p = p_q;

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Rotating-priority arbiter. The requester at ptr has top priority, the
//   search wraps NREQ-1 -> 0. On accept the pointer moves to grant_id+1.
//   Ports:
//     clk          in   clock
//     rst_n        in   asynchronous active-low reset (ptr -> 0)
//     req          in   [NREQ-1:0] request vector
//     accept       in   grant was taken this cycle
//     grant        out  [NREQ-1:0] one-hot grant (combinational)
//     grant_id     out  [ID_W-1:0] encoded grant
//     grant_valid  out  any grant asserted
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            accept,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grant_id,
  output logic            grant_valid
);

  logic [ID_W-1:0] ptr_q;

  always_comb begin
    logic [ID_W:0]   idx_sum;
    logic [ID_W-1:0] idx;
    grant       = '0;
    grant_id    = '0;
    grant_valid = 1'b0;
    idx_sum     = '0;
    idx         = '0;
    for (int k = 0; k < NREQ; k++) begin
      // ptr + k, wrapped without a general modulo
      idx_sum = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (idx_sum >= (ID_W+1)'(NREQ)) begin
        idx_sum = idx_sum - (ID_W+1)'(NREQ);
      end
      idx = idx_sum[ID_W-1:0];
      if (!grant_valid && req[idx]) begin
        grant[idx]  = 1'b1;
        grant_id    = idx;
        grant_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (accept && grant_valid) begin
      ptr_q <= (grant_id == ID_W'(NREQ-1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/mult_rr_scheduler.sv
// mult_rr_scheduler
//   Shares one pipelined_multiplier_8bit between NREQ requesters using
//   round-robin arbitration, one issue per cycle. A tag pipe running beside
//   the multiplier carries {valid, id} so each product returns tagged with
//   its requester, 5 cycles after the handshake, in issue order.
//   Optional feature macro: MULT_RR_STATS_EN (per-requester saturating grant
//   counters). Without it stat_cnt reads 0 and stat_clr is ignored.
//   Ports:
//     clk        in   clock
//     rst_n      in   asynchronous active-low reset
//     req_valid  in   [NREQ-1:0]     per-requester valid
//     req_ready  out  [NREQ-1:0]     one-hot grant (combinational)
//     req_a      in   [NREQ*8-1:0]   operand A, requester i at [8*i+:8]
//     req_b      in   [NREQ*8-1:0]   operand B, requester i at [8*i+:8]
//     rsp_valid  out  result pulse, no backpressure
//     rsp_id     out  [ID_W-1:0]     requester of the result
//     rsp_p      out  [15:0]         product, holds last value when idle
//     busy       out  any op in flight
//     stat_clr   in   synchronous clear of grant counters
//     stat_cnt   out  [NREQ*CNT_W-1:0] grant counters
module mult_rr_scheduler
  import mult_rr_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int CNT_W = 16,
  localparam int ID_W  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [PROD_W-1:0]     rsp_p,
  output logic                  busy,
  input  logic                  stat_clr,
  output logic [NREQ*CNT_W-1:0] stat_cnt
);

  localparam int LAST = MULT_LAT - 1;

  logic [NREQ-1:0]   grant;
  logic [ID_W-1:0]   grant_id;
  logic              handshake;
  logic [DATA_W-1:0] mult_a, mult_b;
  logic [PROD_W-1:0] mult_p;
  logic [PROD_W-1:0] p_hold_q;
  tag_t              tag_q [MULT_LAT];

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req_valid),
    .accept     (handshake),
    .grant      (grant),
    .grant_id   (grant_id),
    .grant_valid(handshake)
  );

  // Grants only exist for valid requesters, so any grant is a handshake.
  assign req_ready = grant;

  // One-hot AND-OR operand mux; zero operands when nothing is granted.
  always_comb begin
    mult_a = '0;
    mult_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        mult_a = mult_a | req_a[DATA_W*i +: DATA_W];
        mult_b = mult_b | req_b[DATA_W*i +: DATA_W];
      end
    end
  end

  pipelined_multiplier_8bit u_mult (
    .clk(clk),
    .rst(~rst_n),
    .a  (mult_a),
    .b  (mult_b),
    .p  (mult_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MULT_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= '{v: handshake, id: TAG_ID_W'(grant_id)};
      for (int i = 1; i < MULT_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Multiplier output changes every cycle; keep the last real result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_hold_q <= '0;
    end else if (tag_q[LAST].v) begin
      p_hold_q <= mult_p;
    end
  end

  assign rsp_valid = tag_q[LAST].v;
  assign rsp_id    = tag_q[LAST].id[ID_W-1:0];
  assign rsp_p     = tag_q[LAST].v ? mult_p : p_hold_q;

  // Tag IDs are sized for 8 requesters; upper bits are zero for smaller NREQ.
  logic [TAG_ID_W-1:0] unused_rsp_tag_id;
  assign unused_rsp_tag_id = tag_q[LAST].id;

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < MULT_LAT; i++) begin
      busy = busy | tag_q[i].v;
    end
  end

`ifdef MULT_RR_STATS_EN
  logic [CNT_W-1:0] cnt_q [NREQ];

  // Clear has priority over a same-cycle increment; counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (stat_clr) begin
      for (int i = 0; i < NREQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_stat
    assign stat_cnt[CNT_W*gi +: CNT_W] = cnt_q[gi];
  end
`else
  assign stat_cnt = '0;

  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
`endif

endmodule
